icache: RTL and testbench

- Direct-mapped instruction cache between the instruction fetch stage and the memory controller.
- Serves one outstanding word-fetch request at a time.
  - Hit: answers in 1 cycle.
  - Miss: issues a word read to the memory controller, fills the line, then answers.
- Misprediction flush cancels the pending answer to fetch but still completes the line fill.

---
 rtl/icache.sv | 127 ++++++++++++
 tb/tb_icache.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller.
// One outstanding fetch at a time; a flush cancels the answer but never the line fill.
module icache #(
  parameter int IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iIF_En,
  input  logic [31:0] iIF_Pc,
  output logic        oIF_En,
  output logic [31:0] oIF_Ins,
  output logic        oMC_En,
  output logic [31:0] oMC_Addr,
  input  logic        iMC_En,
  input  logic [31:0] iMC_Dat,
  input  logic        iROB_Mp
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r [LINES];
  logic [31:0]       data_r [LINES];

  logic              if_en_r;
  logic [31:0]       if_ins_r;
  logic              mc_en_r;
  logic [31:0]       mc_addr_r;

  logic [31:0]       pc_word_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [TAG_W-1:0]  req_tag_s;
  logic [IDX_W-1:0]  fill_idx_s;
  logic [TAG_W-1:0]  fill_tag_s;
  logic              hit_s;
  logic              fill_s;

  // Lookup of the incoming request; the pending miss address doubles as the fill address.
  always_comb begin
    pc_word_s  = iIF_Pc & 32'hFFFF_FFFC;
    req_idx_s  = pc_word_s[IDX_W+1:2];
    req_tag_s  = pc_word_s[31:IDX_W+2];
    fill_idx_s = mc_addr_r[IDX_W+1:2];
    fill_tag_s = mc_addr_r[31:IDX_W+2];
    hit_s      = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    if ((state_r != IDLE) && iMC_En && !rst) begin
      fill_s = 1'b1;
    end else begin
      fill_s = 1'b0;
    end
  end

  // Tag and data storage; only the valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[fill_idx_s] <= iMC_Dat;
      tag_r[fill_idx_s]  <= fill_tag_s;
    end
  end

  // Control FSM with registered fetch and memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      valid_r   <= {LINES{1'b0}};
      if_en_r   <= 1'b0;
      if_ins_r  <= 32'd0;
      mc_en_r   <= 1'b0;
      mc_addr_r <= 32'd0;
    end else begin
      if_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (iIF_En && !iROB_Mp) begin
            if (hit_s) begin
              if_en_r  <= 1'b1;
              if_ins_r <= data_r[req_idx_s];
            end else begin
              mc_en_r   <= 1'b1;
              mc_addr_r <= pc_word_s;
              state_r   <= MISS;
            end
          end
        end
        MISS: begin
          if (iMC_En) begin
            valid_r[fill_idx_s] <= 1'b1;
            mc_en_r             <= 1'b0;
            state_r             <= IDLE;
            // A flush landing with the data still fills the line but skips the answer.
            if (!iROB_Mp) begin
              if_en_r  <= 1'b1;
              if_ins_r <= iMC_Dat;
            end
          end else if (iROB_Mp) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (iMC_En) begin
            valid_r[fill_idx_s] <= 1'b1;
            mc_en_r             <= 1'b0;
            state_r             <= IDLE;
          end
        end
        default: begin
          mc_en_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign oIF_En   = if_en_r;
  assign oIF_Ins  = if_ins_r;
  assign oMC_En   = mc_en_r;
  assign oMC_Addr = mc_addr_r;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// against a line-level reference model of a direct-mapped cache.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        iIF_En;
  logic [31:0] iIF_Pc;
  logic        oIF_En;
  logic [31:0] oIF_Ins;
  logic        oMC_En;
  logic [31:0] oMC_Addr;
  logic        iMC_En;
  logic [31:0] iMC_Dat;
  logic        iROB_Mp;

  int checks = 0;
  int errors = 0;

  // Reference model: which word address each line currently holds, plus backing memory.
  bit          m_valid [256];
  logic [31:0] m_addr  [256];
  logic [31:0] mem [logic [31:0]];

  icache #(.IDX_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .iIF_En  (iIF_En),
    .iIF_Pc  (iIF_Pc),
    .oIF_En  (oIF_En),
    .oIF_Ins (oIF_Ins),
    .oMC_En  (oMC_En),
    .oMC_Addr(oMC_Addr),
    .iMC_En  (iMC_En),
    .iMC_Dat (iMC_Dat),
    .iROB_Mp (iROB_Mp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  function automatic bit model_hit(input logic [31:0] w);
    int idx;
    idx = int'(w[9:2]);
    return m_valid[idx] && (m_addr[idx] == w);
  endfunction

  task automatic model_fill(input logic [31:0] w);
    int idx;
    idx = int'(w[9:2]);
    m_valid[idx] = 1'b1;
    m_addr[idx]  = w;
  endtask

  task automatic ensure_mem(input logic [31:0] w);
    if (!mem.exists(w)) mem[w] = $urandom;
  endtask

  // Ordinary fetch: hit answers next edge, miss waits lat cycles for memory.
  task automatic do_fetch(input logic [31:0] pc, input int lat);
    logic [31:0] w;
    w = pc & 32'hFFFF_FFFC;
    ensure_mem(w);
    iIF_Pc = pc;
    iIF_En = 1'b1;
    tick();
    iIF_En = 1'b0;
    iIF_Pc = $urandom;
    if (model_hit(w)) begin
      chk("hit_en", 32'(oIF_En), 32'd1);
      chk("hit_ins", oIF_Ins, mem[w]);
      chk("hit_mc_en", 32'(oMC_En), 32'd0);
    end else begin
      chk("miss_mc_en", 32'(oMC_En), 32'd1);
      chk("miss_addr", oMC_Addr, w);
      chk("miss_if_en", 32'(oIF_En), 32'd0);
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("miss_hold_en", 32'(oMC_En), 32'd1);
        chk("miss_hold_addr", oMC_Addr, w);
      end
      iMC_En  = 1'b1;
      iMC_Dat = mem[w];
      tick();
      iMC_En  = 1'b0;
      iMC_Dat = $urandom;
      chk("fill_if_en", 32'(oIF_En), 32'd1);
      chk("fill_ins", oIF_Ins, mem[w]);
      chk("fill_mc_off", 32'(oMC_En), 32'd0);
      model_fill(w);
    end
    tick();
    chk("pulse_end", 32'(oIF_En), 32'd0);
    chk("ins_hold", oIF_Ins, mem[w]);
  endtask

  // Miss on pc (must not be cached) with a flush; same=1 puts the flush on the data cycle.
  task automatic flush_miss(input logic [31:0] pc, input int lat, input bit same);
    logic [31:0] w;
    w = pc & 32'hFFFF_FFFC;
    ensure_mem(w);
    iIF_Pc = pc;
    iIF_En = 1'b1;
    tick();
    iIF_En = 1'b0;
    chk("fm_mc_en", 32'(oMC_En), 32'd1);
    chk("fm_addr", oMC_Addr, w);
    if (!same) begin
      iROB_Mp = 1'b1;
      tick();
      iROB_Mp = 1'b0;
      chk("drain_mc_en", 32'(oMC_En), 32'd1);
      chk("drain_if_en", 32'(oIF_En), 32'd0);
      for (int i = 0; i < lat; i++) begin
        iROB_Mp = 1'($urandom_range(0, 1));
        iIF_En  = 1'b1;
        iIF_Pc  = $urandom;
        tick();
        chk("drain_hold_en", 32'(oMC_En), 32'd1);
        chk("drain_hold_addr", oMC_Addr, w);
        chk("drain_no_ans", 32'(oIF_En), 32'd0);
      end
      iIF_En  = 1'b0;
    end
    iROB_Mp = same;
    iMC_En  = 1'b1;
    iMC_Dat = mem[w];
    tick();
    iROB_Mp = 1'b0;
    iMC_En  = 1'b0;
    chk("fm_mc_off", 32'(oMC_En), 32'd0);
    chk("fm_no_ans", 32'(oIF_En), 32'd0);
    model_fill(w);
    tick();
    chk("fm_after", 32'(oIF_En), 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1; iIF_En = 1'b0; iIF_Pc = 32'd0;
    iMC_En = 1'b0; iMC_Dat = 32'd0; iROB_Mp = 1'b0;
    model_clear();
    mem[32'h10]  = 32'h00A0_0093;
    mem[32'h410] = 32'h1234_5678;
    mem[32'h20]  = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("rst_if_en", 32'(oIF_En), 32'd0);
    chk("rst_ins", oIF_Ins, 32'd0);
    chk("rst_mc_en", 32'(oMC_En), 32'd0);
    chk("rst_addr", oMC_Addr, 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss, hit, conflict eviction.
    do_fetch(32'h10, 2);
    do_fetch(32'h10, 0);
    do_fetch(32'h410, 1);
    do_fetch(32'h10, 3);
    do_fetch(32'h10, 0);

    // Flush mid-miss, then the drained line hits.
    flush_miss(32'h20, 2, 1'b0);
    do_fetch(32'h20, 0);
    flush_miss(32'h44, 0, 1'b1);
    do_fetch(32'h44, 0);

    // Flush together with a hit, and with a would-be miss: both ignored.
    iIF_Pc = 32'h10; iIF_En = 1'b1; iROB_Mp = 1'b1;
    tick();
    chk("fh_same_if", 32'(oIF_En), 32'd0);
    iIF_Pc = 32'h88;
    tick();
    iIF_En = 1'b0; iROB_Mp = 1'b0;
    chk("fh_same_miss_if", 32'(oIF_En), 32'd0);
    chk("fh_same_miss_mc", 32'(oMC_En), 32'd0);
    // Flush the cycle after a hit: no further answer appears.
    iIF_Pc = 32'h10; iIF_En = 1'b1;
    tick();
    iIF_En = 1'b0; iROB_Mp = 1'b1;
    tick();
    iROB_Mp = 1'b0;
    chk("fh_next_if", 32'(oIF_En), 32'd0);
    chk("fh_next_mc", 32'(oMC_En), 32'd0);

    // Stray memory data while idle is ignored.
    iMC_En = 1'b1; iMC_Dat = 32'hBAD0_BAD0;
    tick();
    iMC_En = 1'b0;
    chk("stray_if", 32'(oIF_En), 32'd0);
    do_fetch(32'h10, 0);

    // Reset clears the cache.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    do_fetch(32'h10, 1);

    // Reset mid-miss abandons the fill.
    iIF_Pc = 32'h30; iIF_En = 1'b1;
    tick();
    iIF_En = 1'b0;
    chk("rm_mc_en", 32'(oMC_En), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk("rm_mc_off", 32'(oMC_En), 32'd0);
    chk("rm_addr", oMC_Addr, 32'd0);
    iMC_En = 1'b1; iMC_Dat = 32'h5555_AAAA;
    tick();
    iMC_En = 1'b0;
    chk("rm_stray_if", 32'(oIF_En), 32'd0);
    do_fetch(32'h30, 0);

    // Randomized traffic over a few indices and tags to force hits and conflicts.
    for (int n = 0; n < 60; n++) begin
      pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 2)
         | 32'($urandom_range(0, 3));
      if (!model_hit(pc & 32'hFFFF_FFFC) && ($urandom_range(0, 3) == 0))
        flush_miss(pc, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else
        do_fetch(pc, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
